// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the float-to-integer converter
package fp_pkg;

  typedef enum logic [2:0] {
    ST_GET,
    ST_UNPACK,
    ST_SPECIAL,
    ST_ALIGN,
    ST_ROUND,
    ST_PACK,
    ST_PUT
  } state_t;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int         FP_BIAS    = 127;
  localparam logic [7:0] FP_EXP_MAX = 8'd255;

  localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;

  // Saturation value for infinities and out-of-range magnitudes.
  function automatic logic [31:0] sat_value(input logic sign, input logic is_signed);
    if (is_signed) return sign ? INT_MIN : INT_MAX;
    else           return sign ? 32'd0   : UINT_MAX;
  endfunction

endpackage

// File: rtl/fp_to_int_converter_if.sv
// rtl/fp_to_int_converter_if.sv - operand and result strobe/ack handshake bundle
interface fp_to_int_converter_if;
  logic [31:0] in_val;
  logic [2:0]  in_rm;
  logic        in_signed;
  logic        in_val_stb;
  logic        in_val_ack;
  logic [31:0] out_int;
  logic        out_nv;
  logic        out_nx;
  logic        out_int_stb;
  logic        out_int_ack;

  modport master (
    output in_val, in_rm, in_signed, in_val_stb, out_int_ack,
    input  in_val_ack, out_int, out_nv, out_nx, out_int_stb
  );

  modport slave (
    input  in_val, in_rm, in_signed, in_val_stb, out_int_ack,
    output in_val_ack, out_int, out_nv, out_nx, out_int_stb
  );
endinterface

// File: rtl/fp2int_round_sat.sv
// rtl/fp2int_round_sat.sv - rounding increment, range saturation and NV/NX flags
module fp2int_round_sat
  import fp_pkg::*;
(
  input  logic [32:0] mag,
  input  logic        guard,
  input  logic        sticky,
  input  logic        sign,
  input  logic [2:0]  rm,
  input  logic        is_signed,
  output logic [31:0] result,
  output logic        nv,
  output logic        nx
);

  logic        inc;
  logic        rne_inc;
  logic [32:0] rmag;

  assign rne_inc = guard & (sticky | mag[0]);

  always_comb begin
    inc = rne_inc;
    case (rm)
      RM_RNE:  inc = rne_inc;
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = (guard | sticky) & sign;
      RM_RUP:  inc = (guard | sticky) & ~sign;
      RM_RMM:  inc = guard;
      default: inc = rne_inc;
    endcase
  end

  // Magnitude never exceeds 32 bits before rounding, so the 33-bit sum cannot wrap.
  assign rmag = mag + {32'd0, inc};

  always_comb begin
    nv     = 1'b0;
    result = rmag[31:0];
    if (is_signed) begin
      if (!sign && rmag > {1'b0, INT_MAX}) begin
        result = INT_MAX;
        nv     = 1'b1;
      end else if (sign && rmag > {1'b0, INT_MIN}) begin
        result = INT_MIN;
        nv     = 1'b1;
      end else begin
        result = sign ? (~rmag[31:0] + 32'd1) : rmag[31:0];
      end
    end else begin
      if (!sign && rmag[32]) begin
        result = UINT_MAX;
        nv     = 1'b1;
      end else if (sign && rmag != 33'd0) begin
        result = 32'd0;
        nv     = 1'b1;
      end
    end
    nx = (guard | sticky) & ~nv;
  end

endmodule

// File: rtl/fp_to_int_converter.sv
// rtl/fp_to_int_converter.sv - IEEE single to 32-bit integer, FCVT.W.S / FCVT.WU.S semantics
module fp_to_int_converter
  import fp_pkg::*;
#(
  parameter int MAX_RSHIFT = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  fp_to_int_converter_if.slave  bus
);

  localparam logic signed [9:0] ALIGN_EXP = 10'sd23;
  localparam logic signed [9:0] OVF_EXP   = 10'sd32;
  localparam logic signed [9:0] MIN_EXP   = 10'(23 - MAX_RSHIFT);

  state_t             state_q, state_d;
  logic [31:0]        val_q, val_d;
  logic [2:0]         rm_q, rm_d;
  logic               signed_q, signed_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        sig_q, sig_d;
  logic [32:0]        mag_q, mag_d;
  logic               guard_q, guard_d, sticky_q, sticky_d;
  logic [31:0]        res_q, res_d;
  logic               res_nv_q, res_nv_d, res_nx_q, res_nx_d;
  logic               ack_q, ack_d, stb_q, stb_d;
  logic [31:0]        int_q, int_d;
  logic               nv_q, nv_d, nx_q, nx_d;

  logic [31:0]        rs_result;
  logic               rs_nv, rs_nx;
  logic               exp_all1, mant_nz, exp_zero;

  assign exp_all1 = (val_q[30:23] == FP_EXP_MAX);
  assign exp_zero = (val_q[30:23] == 8'd0);
  assign mant_nz  = |val_q[22:0];

  fp2int_round_sat u_round_sat (
    .mag       (mag_q),
    .guard     (guard_q),
    .sticky    (sticky_q),
    .sign      (sign_q),
    .rm        (rm_q),
    .is_signed (signed_q),
    .result    (rs_result),
    .nv        (rs_nv),
    .nx        (rs_nx)
  );

  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    rm_d     = rm_q;
    signed_d = signed_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    sig_d    = sig_q;
    mag_d    = mag_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    res_d    = res_q;
    res_nv_d = res_nv_q;
    res_nx_d = res_nx_q;
    ack_d    = ack_q;
    stb_d    = stb_q;
    int_d    = int_q;
    nv_d     = nv_q;
    nx_d     = nx_q;
    case (state_q)
      ST_GET: begin
        ack_d = 1'b1;
        if (ack_q && bus.in_val_stb) begin
          val_d    = bus.in_val;
          rm_d     = bus.in_rm;
          signed_d = bus.in_signed;
          ack_d    = 1'b0;
          state_d  = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        sign_d  = val_q[31];
        exp_d   = 10'({2'b00, val_q[30:23]}) - 10'(FP_BIAS);
        sig_d   = {~exp_zero, val_q[22:0]};
        state_d = ST_SPECIAL;
      end
      ST_SPECIAL: begin
        stb_d   = 1'b1;
        nx_d    = 1'b0;
        state_d = ST_PUT;
        if (exp_all1 && mant_nz) begin
          int_d = sat_value(1'b0, signed_q);
          nv_d  = 1'b1;
        end else if (exp_all1 || exp_q >= OVF_EXP) begin
          int_d = sat_value(sign_q, signed_q);
          nv_d  = 1'b1;
        end else if (val_q[30:0] == 31'd0) begin
          int_d = 32'd0;
          nv_d  = 1'b0;
        end else begin
          stb_d = 1'b0;
          // Too far below 1.0 to walk bit by bit: the value is all sticky.
          if (exp_zero || exp_q < MIN_EXP) begin
            mag_d    = 33'd0;
            guard_d  = 1'b0;
            sticky_d = 1'b1;
            state_d  = ST_ROUND;
          end else begin
            mag_d    = {9'd0, sig_q};
            guard_d  = 1'b0;
            sticky_d = 1'b0;
            state_d  = (exp_q == ALIGN_EXP) ? ST_ROUND : ST_ALIGN;
          end
        end
      end
      ST_ALIGN: begin
        if (exp_q > ALIGN_EXP) begin
          mag_d = {mag_q[31:0], 1'b0};
          exp_d = exp_q - 10'sd1;
        end else begin
          sticky_d = sticky_q | guard_q;
          guard_d  = mag_q[0];
          mag_d    = {1'b0, mag_q[32:1]};
          exp_d    = exp_q + 10'sd1;
        end
        if (exp_d == ALIGN_EXP) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        res_d    = rs_result;
        res_nv_d = rs_nv;
        res_nx_d = rs_nx;
        state_d  = ST_PACK;
      end
      ST_PACK: begin
        int_d   = res_q;
        nv_d    = res_nv_q;
        nx_d    = res_nx_q;
        stb_d   = 1'b1;
        state_d = ST_PUT;
      end
      ST_PUT: begin
        if (bus.out_int_ack) begin
          stb_d   = 1'b0;
          state_d = ST_GET;
        end
      end
      default: state_d = ST_GET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_GET;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
      int_q   <= 32'd0;
      nv_q    <= 1'b0;
      nx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
      int_q   <= int_d;
      nv_q    <= nv_d;
      nx_q    <= nx_d;
    end
  end

  always_ff @(posedge clk) begin
    val_q    <= val_d;
    rm_q     <= rm_d;
    signed_q <= signed_d;
    sign_q   <= sign_d;
    exp_q    <= exp_d;
    sig_q    <= sig_d;
    mag_q    <= mag_d;
    guard_q  <= guard_d;
    sticky_q <= sticky_d;
    res_q    <= res_d;
    res_nv_q <= res_nv_d;
    res_nx_q <= res_nx_d;
  end

  assign bus.in_val_ack  = ack_q;
  assign bus.out_int_stb = stb_q;
  assign bus.out_int     = int_q;
  assign bus.out_nv      = nv_q;
  assign bus.out_nx      = nx_q;

endmodule

// File: tb/tb_fp_to_int_converter.sv
// tb/tb_fp_to_int_converter.sv - directed self-checking bench for fp_to_int_converter
module tb_fp_to_int_converter;

  typedef struct {
    logic [31:0] v;
    logic [2:0]  rm;
    logic        sg;
    logic [31:0] r;
    logic        nv;
    logic        nx;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  fp_to_int_converter_if bus();

  fp_to_int_converter #(.MAX_RSHIFT(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [31:0] v, input logic [2:0] rm, input logic sg,
                       output logic [31:0] r, output logic nv, output logic nx,
                       output int lat);
    int wait_cnt;
    wait_cnt = 0;
    bus.in_val      = v;
    bus.in_rm       = rm;
    bus.in_signed   = sg;
    bus.in_val_stb  = 1'b1;
    bus.out_int_ack = 1'b0;
    while (bus.in_val_ack !== 1'b1 && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    @(posedge clk); #1;
    bus.in_val_stb = 1'b0;
    lat = 0;
    while (bus.out_int_stb !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (wait_cnt >= 50 || lat >= 100) begin
      errors++;
      $display("FAIL op_timeout val=%h got wait=%0d lat=%0d required wait<50 lat<100", v, wait_cnt, lat);
    end
    r  = bus.out_int;
    nv = bus.out_nv;
    nx = bus.out_nx;
    bus.out_int_ack = 1'b1;
    @(posedge clk); #1;
    bus.out_int_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset           = 1'b1;
    bus.in_val      = 32'd0;
    bus.in_rm       = 3'd0;
    bus.in_signed   = 1'b0;
    bus.in_val_stb  = 1'b0;
    bus.out_int_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_val_ack, bus.out_int_stb, bus.out_int, bus.out_nv, bus.out_nx} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b stb=%b int=%h nv=%b nx=%b required all zero",
               bus.in_val_ack, bus.out_int_stb, bus.out_int, bus.out_nv, bus.out_nx);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_val_ack !== 1'b1) begin
      errors++;
      $display("FAIL reset_ack_rise got=%b required=1", bus.in_val_ack);
    end
  endtask

  task automatic test_rounding;
    vec_t vecs[7] = '{
      '{32'h40600000, 3'd0, 1'b1, 32'h00000004, 1'b0, 1'b1, 26},
      '{32'h40600000, 3'd1, 1'b1, 32'h00000003, 1'b0, 1'b1, 26},
      '{32'h40600000, 3'd5, 1'b1, 32'h00000004, 1'b0, 1'b1, -1},
      '{32'hC0200000, 3'd0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, -1},
      '{32'hC0200000, 3'd4, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b1, -1},
      '{32'hC0200000, 3'd3, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, -1},
      '{32'h41200000, 3'd2, 1'b1, 32'h0000000A, 1'b0, 1'b0, 24}
    };
    logic [31:0] r;
    logic nv, nx;
    int lat;
    foreach (vecs[i]) begin
      do_op(vecs[i].v, vecs[i].rm, vecs[i].sg, r, nv, nx, lat);
      checks++;
      if ({r, nv, nx} !== {vecs[i].r, vecs[i].nv, vecs[i].nx}) begin
        errors++;
        $display("FAIL round_%0d val=%h rm=%0d got int=%h nv=%b nx=%b required int=%h nv=%b nx=%b",
                 i, vecs[i].v, vecs[i].rm, r, nv, nx, vecs[i].r, vecs[i].nv, vecs[i].nx);
      end
      if (vecs[i].lat >= 0) begin
        checks++;
        if (lat != vecs[i].lat) begin
          errors++;
          $display("FAIL round_latency_%0d got=%0d required=%0d", i, lat, vecs[i].lat);
        end
      end
    end
  endtask

  task automatic test_range;
    vec_t vecs[5] = '{
      '{32'h4F000000, 3'd0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 12},
      '{32'h4F000000, 3'd0, 1'b0, 32'h80000000, 1'b0, 1'b0, -1},
      '{32'hCF000000, 3'd0, 1'b1, 32'h80000000, 1'b0, 1'b0, -1},
      '{32'hBE800000, 3'd0, 1'b0, 32'h00000000, 1'b0, 1'b1, 4},
      '{32'hBE800000, 3'd2, 1'b0, 32'h00000000, 1'b1, 1'b0, -1}
    };
    logic [31:0] r;
    logic nv, nx;
    int lat;
    foreach (vecs[i]) begin
      do_op(vecs[i].v, vecs[i].rm, vecs[i].sg, r, nv, nx, lat);
      checks++;
      if ({r, nv, nx} !== {vecs[i].r, vecs[i].nv, vecs[i].nx}) begin
        errors++;
        $display("FAIL range_%0d val=%h got int=%h nv=%b nx=%b required int=%h nv=%b nx=%b",
                 i, vecs[i].v, r, nv, nx, vecs[i].r, vecs[i].nv, vecs[i].nx);
      end
      if (vecs[i].lat >= 0) begin
        checks++;
        if (lat != vecs[i].lat) begin
          errors++;
          $display("FAIL range_latency_%0d got=%0d required=%0d", i, lat, vecs[i].lat);
        end
      end
    end
  endtask

  task automatic test_specials;
    vec_t vecs[6] = '{
      '{32'h7FC00000, 3'd0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, -1},
      '{32'h7FC00000, 3'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, -1},
      '{32'hFF800000, 3'd0, 1'b0, 32'h00000000, 1'b1, 1'b0, -1},
      '{32'h80000000, 3'd0, 1'b1, 32'h00000000, 1'b0, 1'b0, -1},
      '{32'h00000001, 3'd3, 1'b1, 32'h00000001, 1'b0, 1'b1, -1},
      '{32'h00000001, 3'd0, 1'b1, 32'h00000000, 1'b0, 1'b1, -1}
    };
    logic [31:0] r;
    logic nv, nx;
    int lat;
    foreach (vecs[i]) begin
      do_op(vecs[i].v, vecs[i].rm, vecs[i].sg, r, nv, nx, lat);
      checks++;
      if ({r, nv, nx} !== {vecs[i].r, vecs[i].nv, vecs[i].nx}) begin
        errors++;
        $display("FAIL special_%0d val=%h got int=%h nv=%b nx=%b required int=%h nv=%b nx=%b",
                 i, vecs[i].v, r, nv, nx, vecs[i].r, vecs[i].nv, vecs[i].nx);
      end
    end
  endtask

  task automatic test_handshake;
    int cnt;
    bus.in_val      = 32'h41200000;
    bus.in_rm       = 3'd0;
    bus.in_signed   = 1'b1;
    bus.in_val_stb  = 1'b1;
    bus.out_int_ack = 1'b0;
    cnt = 0;
    while (bus.in_val_ack !== 1'b1 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    @(posedge clk); #1;
    bus.in_val = 32'h40600000;
    cnt = 0;
    while (bus.out_int_stb !== 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt >= 100) begin
      errors++;
      $display("FAIL hs_timeout got lat=%0d required<100", cnt);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({bus.out_int_stb, bus.out_int, bus.out_nv, bus.out_nx, bus.in_val_ack} !==
          {1'b1, 32'h0000000A, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hs_hold_%0d got stb=%b int=%h nv=%b nx=%b ack=%b required stb=1 int=0000000a nv=0 nx=0 ack=0",
                 k, bus.out_int_stb, bus.out_int, bus.out_nv, bus.out_nx, bus.in_val_ack);
      end
      @(posedge clk); #1;
    end
    bus.in_val_stb  = 1'b0;
    bus.out_int_ack = 1'b1;
    @(posedge clk); #1;
    bus.out_int_ack = 1'b0;
    checks++;
    if ({bus.out_int_stb, bus.in_val_ack} !== 2'b00) begin
      errors++;
      $display("FAIL hs_release got stb=%b ack=%b required stb=0 ack=0", bus.out_int_stb, bus.in_val_ack);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.in_val_ack !== 1'b1) begin
      errors++;
      $display("FAIL hs_ack_return got=%b required=1", bus.in_val_ack);
    end
  endtask

  task automatic test_reset_mid;
    int cnt;
    logic [31:0] r;
    logic nv, nx;
    int lat;
    bus.in_val      = 32'h3F800000;
    bus.in_rm       = 3'd0;
    bus.in_signed   = 1'b1;
    bus.in_val_stb  = 1'b1;
    bus.out_int_ack = 1'b0;
    cnt = 0;
    while (bus.in_val_ack !== 1'b1 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    @(posedge clk); #1;
    bus.in_val_stb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.in_val_ack, bus.out_int_stb, bus.out_int, bus.out_nv, bus.out_nx} !== 36'd0) begin
      errors++;
      $display("FAIL midreset_outputs got ack=%b stb=%b int=%h nv=%b nx=%b required all zero",
               bus.in_val_ack, bus.out_int_stb, bus.out_int, bus.out_nv, bus.out_nx);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.in_val_ack, bus.out_int_stb} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_get got ack=%b stb=%b required ack=1 stb=0", bus.in_val_ack, bus.out_int_stb);
    end
    do_op(32'h41200000, 3'd0, 1'b1, r, nv, nx, lat);
    checks++;
    if ({r, nv, nx, lat} !== {32'h0000000A, 1'b0, 1'b0, 32'd24}) begin
      errors++;
      $display("FAIL midreset_after got int=%h nv=%b nx=%b lat=%0d required int=0000000a nv=0 nx=0 lat=24",
               r, nv, nx, lat);
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_range();
    test_specials();
    test_handshake();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1);
  end

endmodule
